// File: rtl/memory_read_responder_pkg.sv
// ---------------------------------------------------------------------------
// memory_read_responder_pkg
// Shared definitions for the memory read responder and its pipeline stages:
// word width, default/maximum read latency, pending-counter width, the
// response-stage field layout {valid, oor, data} and the pending-counter
// step function.
// ---------------------------------------------------------------------------
package memory_read_responder_pkg;

    localparam int WORD_W          = 16;
    localparam int DEFAULT_LATENCY = 4;
    localparam int MAX_LATENCY     = 8;
    localparam int PEND_W          = 4;   // holds 0..MAX_LATENCY

    // One response pipeline slot.
    typedef struct packed {
        logic              valid;
        logic              oor;
        logic [WORD_W-1:0] data;
    } resp_stage_t;

    // Up/down step of the in-flight read counter; simultaneous issue and
    // retire leaves the count unchanged.
    function automatic logic [PEND_W-1:0] pending_step(
        input logic [PEND_W-1:0] cur,
        input logic              inc,
        input logic              dec
    );
        logic [PEND_W-1:0] res;
        res = cur;
        if (inc && !dec) begin
            res = cur + 1'b1;
        end else if (dec && !inc) begin
            res = cur - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_resp_stage.sv
// ---------------------------------------------------------------------------
// mem_resp_stage
// One register slot of the read-response pipeline.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_valid/i_oor/i_data  slot contents from the previous stage
//   o_valid/o_oor/o_data  registered slot contents
// valid/oor follow the input every edge; data is only captured with a valid
// slot, so the last returned word stays visible on idle cycles.
// ---------------------------------------------------------------------------
module mem_resp_stage
    import memory_read_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_oor,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_valid,
    output logic              o_oor,
    output logic [WORD_W-1:0] o_data
);

    logic              r_valid;
    logic              r_oor;
    logic [WORD_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_oor   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_valid;
            r_oor   <= i_oor;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_oor   = r_oor;
    assign o_data  = r_data;

endmodule

// File: rtl/memory_read_responder.sv
// ---------------------------------------------------------------------------
// memory_read_responder
// Memory-side responder for the cache fill protocol. Accepts one word
// request per cycle, writes land in the backing array at the sampling edge,
// reads return exactly LATENCY cycles later (request edge N, valid in the
// cycle after edge N+LATENCY-1). Fully pipelined, no backpressure.
// Parameters:
//   LATENCY     read latency, legal 1..8
//   ADDR_W      byte-address width (word index = address[ADDR_W-1:1])
//   DEPTH_LOG2  log2 of backing-array words, must be <= ADDR_W-1
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable, wr         request valid, 1 = write / 0 = read
//   address, data_in   byte address (bit 0 ignored), write data
//   data_out           read data, holds last returned value when idle
//   memory_data_valid  one-cycle pulse per read response
//   pending            reads issued and not yet retired (0..LATENCY)
//   out_of_range       pulses with the response of an out-of-range read
// ---------------------------------------------------------------------------
module memory_read_responder
    import memory_read_responder_pkg::*;
#(
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] address,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              memory_data_valid,
    output logic [PEND_W-1:0] pending,
    output logic              out_of_range
);

    localparam int IDX_W = ADDR_W - 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // ---------------- request decode ----------------
    logic [IDX_W-1:0]      w_idx;
    logic [DEPTH_LOG2-1:0] w_word_idx;
    logic                  w_addr_oor;
    logic                  w_rd_issue;
    logic                  w_wr_issue;
    logic                  w_unused_addr_lsb;

    assign w_idx             = address[ADDR_W-1:1];
    assign w_word_idx        = w_idx[DEPTH_LOG2-1:0];
    assign w_unused_addr_lsb = address[0];
    // Qualified by enable so an undefined address on idle cycles never
    // reaches any state.
    assign w_rd_issue        = enable & ~wr;
    assign w_wr_issue        = enable & wr;

    generate
        if (DEPTH_LOG2 < IDX_W) begin : g_range_check
            assign w_addr_oor = |w_idx[IDX_W-1:DEPTH_LOG2];
        end else begin : g_full_range
            assign w_addr_oor = 1'b0;
        end
    endgenerate

    // ---------------- backing array ----------------
    // Not reset: contents survive rst_n. The read port is registered, so the
    // word is snapshotted at the issue edge and later writes cannot alter it.
    logic [WORD_W-1:0] r_mem [0:DEPTH-1];
    logic [WORD_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (w_wr_issue && !w_addr_oor) begin
            r_mem[w_word_idx] <= data_in;
        end
        if (w_rd_issue && !w_addr_oor) begin
            r_rd_data <= r_mem[w_word_idx];
        end
    end

    // ---------------- stage 1 control ----------------
    // r_s1_zero forces the stage-1 data to zero: set by reset (so data_out
    // reads 0 before the first response) and by an out-of-range read.
    // It only changes on a read issue, so with LATENCY=1 data_out still holds.
    logic r_s1_valid;
    logic r_s1_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_zero  <= 1'b1;
        end else begin
            r_s1_valid <= w_rd_issue;
            if (w_rd_issue) begin
                r_s1_zero <= w_addr_oor;
            end
        end
    end

    // ---------------- response pipeline ----------------
    logic [LATENCY-1:0] w_valid;
    logic [LATENCY-1:0] w_oor;
    logic [WORD_W-1:0]  w_data [0:LATENCY-1];

    assign w_valid[0] = r_s1_valid;
    assign w_oor[0]   = r_s1_valid & r_s1_zero;
    assign w_data[0]  = r_s1_zero ? '0 : r_rd_data;

    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
            mem_resp_stage u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_valid (w_valid[gi-1]),
                .i_oor   (w_oor[gi-1]),
                .i_data  (w_data[gi-1]),
                .o_valid (w_valid[gi]),
                .o_oor   (w_oor[gi]),
                .o_data  (w_data[gi])
            );
        end
    endgenerate

    resp_stage_t w_out;

    assign w_out = '{valid: w_valid[LATENCY-1],
                     oor:   w_oor[LATENCY-1],
                     data:  w_data[LATENCY-1]};

    assign data_out          = w_out.data;
    assign memory_data_valid = w_out.valid;
    assign out_of_range      = w_out.valid & w_out.oor;

    // ---------------- in-flight counter ----------------
    // A read counts as pending through its response cycle; it retires at the
    // edge that ends that cycle. Peak is therefore LATENCY.
    logic [PEND_W-1:0] r_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= pending_step(r_pending, w_rd_issue, w_out.valid);
        end
    end

    assign pending = r_pending;

endmodule
